alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 141 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequences one operation at a time through an external ALU.
//
//   IDLE    -> latch request on accept (req_valid & req_ready)
//   ISSUE   -> drive latched opcode/operands to the ALU
//   CAPTURE -> keep driving; sample alu_out + flags on the closing edge
//   RESP    -> present the result until rsp_ready, then count it
//
// Ports
//   clock, reset            : clock, synchronous active-high reset
//   req_*                   : request handshake (opcode, A, B, destination tag)
//   alu_opcode/alu_a/alu_b  : operation driven to the ALU
//   alu_out, alu_*flags     : ALU result and {Z,N,C,V} flags
//   rsp_*                   : response handshake (data, tag, wen, err)
//   branch_taken            : branch/jump condition (ALU zero flag)
//   flags                   : architectural {Z,N,C,V}, updated by write ops only
//   op_count                : completed-operation counter (wraps)
module alu_issue_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_opcode,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_tag,
  output logic [4:0]  alu_opcode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_neg,
  input  logic        alu_carry,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_tag,
  output logic        rsp_wen,
  output logic        branch_taken,
  output logic        rsp_err,
  output logic [3:0]  flags,
  output logic [15:0] op_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  // Opcode presented to the ALU while nothing is in flight.
  localparam logic [4:0] IDLE_OPCODE = 5'b10000;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
  } req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        wen;
    logic        taken;
    logic        err;
  } rsp_t;

  logic [1:0] state;
  req_t       req_q;
  rsp_t       rsp_q;
  logic       is_branch;
  logic       is_undef;
  logic       drive;

  // Everything that is neither a branch nor undefined is a register write.
  always_comb begin
    is_branch = 1'b0;
    is_undef  = 1'b0;
    case (req_q.opcode)
      5'b00010, 5'b00111, 5'b01010: is_branch = 1'b1;
      5'b01101, 5'b01110, 5'b01111: is_undef  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      req_q    <= '0;
      rsp_q    <= '0;
      flags    <= '0;
      op_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_q <= '{opcode: req_opcode, a: req_a, b: req_b, tag: req_tag};
            state <= ISSUE;
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          rsp_q.tag   <= req_q.tag;
          rsp_q.wen   <= !is_branch && !is_undef;
          rsp_q.taken <= is_branch && alu_zero;
          rsp_q.err   <= is_undef;
          rsp_q.data  <= (is_branch || is_undef) ? '0 : alu_out;
          // Branches and undefined ops must not disturb architectural flags.
          if (!is_branch && !is_undef)
            flags <= {alu_zero, alu_neg, alu_carry, alu_overflow};
          state <= RESP;
        end
        RESP: begin
          // Return to IDLE rather than accepting here, so a new request
          // never overlaps the response handshake.
          if (rsp_ready) begin
            rsp_q    <= '0;
            op_count <= op_count + 16'd1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign drive      = (state == ISSUE) || (state == CAPTURE);
  assign alu_opcode = drive ? req_q.opcode : IDLE_OPCODE;
  assign alu_a      = drive ? req_q.a : '0;
  assign alu_b      = drive ? req_q.b : '0;

  // Response fields are forced to zero outside RESP.
  assign rsp_valid    = (state == RESP);
  assign rsp_data     = rsp_valid ? rsp_q.data  : '0;
  assign rsp_tag      = rsp_valid ? rsp_q.tag   : '0;
  assign rsp_wen      = rsp_valid ? rsp_q.wen   : 1'b0;
  assign branch_taken = rsp_valid ? rsp_q.taken : 1'b0;
  assign rsp_err      = rsp_valid ? rsp_q.err   : 1'b0;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: an ALU model answers the DUT's alu_* outputs,
// and a transaction-level reference (opcode class rules, flags, counter)
// predicts every response. Directed cases first, then random operations.
module tb_alu_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_opcode;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_tag;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        alu_zero, alu_neg, alu_carry, alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_tag;
  logic        rsp_wen;
  logic        branch_taken;
  logic        rsp_err;
  logic [3:0]  flags;
  logic [15:0] op_count;

  alu_issue_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_wen(rsp_wen), .branch_taken(branch_taken),
    .rsp_err(rsp_err), .flags(flags), .op_count(op_count)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // ALU model: returns {Z,N,C,V,result}. bne reports Z when operands differ
  // so that branch_taken follows the zero flag for every branch opcode.
  function automatic logic [35:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        z, c, v;
    r = a ^ b; c = 1'b0; v = 1'b0;
    case (op)
      5'b00000: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      5'b00001, 5'b00010, 5'b00111: begin
        r = a - b; c = (a >= b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      5'b01010, 5'b10000: r = '0;
      5'b10101:           r = a;
      default:            r = a ^ b;
    endcase
    z = (r == 32'd0);
    if (op == 5'b00111) z = (a != b);
    return {z, r[31], c, v, r};
  endfunction

  always_comb {alu_zero, alu_neg, alu_carry, alu_overflow, alu_out} = alu_fn(alu_opcode, alu_a, alu_b);

  // Reference state
  logic [3:0]  m_flags;
  logic [15:0] m_cnt;

  // Runs one transaction. Entered and left at a falling edge with the DUT idle.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input int stall);
    logic [35:0] r;
    logic        br, ud, e_wen, e_tk;
    logic [31:0] e_data;
    r      = alu_fn(op, a, b);
    br     = (op == 5'b00010) || (op == 5'b00111) || (op == 5'b01010);
    ud     = (op == 5'b01101) || (op == 5'b01110) || (op == 5'b01111);
    e_wen  = !br && !ud;
    e_tk   = br && r[35];
    e_data = e_wen ? r[31:0] : 32'd0;
    if (e_wen) m_flags = r[35:32];

    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b; req_tag = tag;
    chk("idle_ready", req_ready, 1);
    chk("idle_alu_op", alu_opcode, 5'b10000);
    chk("idle_alu_a", alu_a, 0);
    chk("idle_alu_b", alu_b, 0);
    @(negedge clock);
    // Scramble request inputs: the DUT must be using its latched copy.
    req_valid = 1'b0; req_opcode = 5'($urandom); req_a = $urandom; req_b = $urandom;
    req_tag = 5'($urandom);
    for (int s = 0; s < 2; s++) begin
      chk("busy_ready", req_ready, 0);
      chk("busy_vld", rsp_valid, 0);
      chk("busy_data", rsp_data, 0);
      chk("busy_alu_op", alu_opcode, op);
      chk("busy_alu_a", alu_a, a);
      chk("busy_alu_b", alu_b, b);
      @(negedge clock);
    end
    for (int s = 0; s <= stall; s++) begin
      chk("rsp_vld", rsp_valid, 1);
      chk("rsp_ready_lo", req_ready, 0);
      chk("rsp_data", rsp_data, e_data);
      chk("rsp_tag", rsp_tag, tag);
      chk("rsp_wen", rsp_wen, e_wen);
      chk("rsp_taken", branch_taken, e_tk);
      chk("rsp_err", rsp_err, ud);
      chk("rsp_flags", flags, m_flags);
      chk("rsp_cnt", op_count, m_cnt);
      if (s == stall) begin
        // Offer a new request in the handshake cycle; it must not be taken.
        rsp_ready = 1'b1; req_valid = 1'b1;
      end
      @(negedge clock);
    end
    m_cnt++;
    rsp_ready = 1'b0; req_valid = 1'b0;
    chk("hs_vld", rsp_valid, 0);
    chk("hs_ready", req_ready, 1);
    chk("hs_cnt", op_count, m_cnt);
    chk("hs_flags", flags, m_flags);
    chk("hs_data", rsp_data, 0);
    chk("hs_wen", rsp_wen, 0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_opcode = '0; req_a = '0; req_b = '0; req_tag = '0;
    m_flags = '0; m_cnt = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_ready", req_ready, 1);
    chk("rst_vld", rsp_valid, 0);
    chk("rst_flags", flags, 0);
    chk("rst_cnt", op_count, 0);
    chk("rst_alu_op", alu_opcode, 5'b10000);

    // Add 5+7
    do_op(5'b00000, 32'd5, 32'd7, 5'd3, 0);
    chk("add_flags", flags, 4'b0000);
    chk("add_cnt", op_count, 1);
    // Set non-zero flags, then branches must leave them alone
    do_op(5'b00001, 32'd1, 32'd2, 5'd4, 1);
    do_op(5'b00010, 32'h55, 32'h55, 5'd5, 0);
    do_op(5'b00010, 32'h55, 32'h56, 5'd6, 0);
    do_op(5'b00111, 32'h55, 32'h56, 5'd7, 0);
    do_op(5'b01010, 32'h0, 32'h0, 5'd8, 0);
    // Backpressure
    do_op(5'b10101, 32'h8000_0000, 32'd0, 5'd9, 10);
    chk("bp_n_flag", flags[2], 1);
    // Undefined
    do_op(5'b01110, 32'h1234, 32'h99, 5'd10, 2);

    // Reset while in CAPTURE, with req_valid and rsp_ready also asserted
    req_valid = 1'b1; req_opcode = 5'b10101; req_a = 32'hFFFF_0000; req_b = 0; req_tag = 5'd11;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1; req_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clock);
    reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    m_flags = '0; m_cnt = '0;
    chk("mid_rst_vld", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_cnt", op_count, 0);
    chk("mid_rst_flags", flags, 0);
    chk("mid_rst_alu_op", alu_opcode, 5'b10000);
    @(negedge clock);
    chk("mid_rst_no_rsp", rsp_valid, 0);
    do_op(5'b00000, 32'd1, 32'd1, 5'd12, 0);

    // Random operations
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom;
      do_op(5'($urandom_range(0, 31)), a, ($urandom_range(0, 1) != 0) ? a : $urandom,
            5'($urandom), $urandom_range(0, 3));
    end

    // Counter wrap. Stepping through 65535 operations would take over 260k
    // cycles, so the counter is deposited just below the wrap point instead.
    dut.op_count = 16'hFFFE;
    m_cnt = 16'hFFFE;
    do_op(5'b10000, $urandom, $urandom, 5'd1, 0);
    chk("pre_wrap_cnt", op_count, 16'hFFFF);
    do_op(5'b10000, $urandom, $urandom, 5'd2, 0);
    chk("wrap_cnt", op_count, 0);
    chk("wrap_z", flags, 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
